// File: rtl/pattern_det_ctrl.sv
// Serial pattern detector: matches a programmable 1..PMAX bit pattern against a
// bit stream, counts matches and stops on an optional target count.
module pattern_det_ctrl #(
  parameter int PMAX = 8,
  parameter int CW   = 8
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            cfg_we,
  input  logic [PMAX-1:0] cfg_pattern,
  input  logic [3:0]      cfg_len,
  input  logic            cfg_overlap,
  input  logic [CW-1:0]   cfg_target,
  input  logic            start,
  input  logic            stop,
  input  logic            in,
  input  logic            in_valid,
  output logic            out,
  output logic            busy,
  output logic            done,
  output logic [CW-1:0]   match_cnt,
  output logic            err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0]      PMAX_L      = 4'(PMAX);
  localparam logic [PMAX-1:0] DEF_PATTERN = PMAX'(3'b101);

  state_t          state_r;
  logic [PMAX-1:0] pattern_r;
  logic [PMAX-1:0] hist_r;
  logic [3:0]      len_r;
  logic [3:0]      fill_r;
  logic            overlap_r;
  logic [CW-1:0]   target_r;
  logic [CW-1:0]   match_cnt_r;
  logic            out_r;
  logic            busy_r;
  logic            done_r;
  logic            err_r;

  logic            cfg_legal_s;
  logic            accept_s;
  logic [PMAX-1:0] hist_nxt_s;
  logic [3:0]      fill_inc_s;
  logic [PMAX-1:0] mask_s;
  logic            match_s;
  logic [CW-1:0]   cnt_inc_s;
  logic            hit_target_s;

  // Low 'len' bits set; selects the live part of pattern and history.
  function automatic logic [PMAX-1:0] len_mask(input logic [3:0] len);
    logic [PMAX-1:0] m;
    m = {PMAX{1'b0}};
    for (int i = 0; i < PMAX; i++) begin
      m[i] = (i < int'(len));
    end
    return m;
  endfunction

  // Match is judged on the history as it will be after the bit is accepted.
  always_comb begin
    cfg_legal_s  = (cfg_len != 4'd0) && (cfg_len <= PMAX_L);
    accept_s     = ((state_r == ARMED) || (state_r == RUN)) && in_valid;
    hist_nxt_s   = {hist_r[PMAX-2:0], in};
    fill_inc_s   = (fill_r >= PMAX_L) ? fill_r : fill_r + 4'd1;
    mask_s       = len_mask(len_r);
    match_s      = accept_s && (fill_inc_s >= len_r) &&
                   ((hist_nxt_s & mask_s) == (pattern_r & mask_s));
    cnt_inc_s    = (&match_cnt_r) ? match_cnt_r : match_cnt_r + {{(CW-1){1'b0}}, 1'b1};
    hit_target_s = match_s && (target_r != {CW{1'b0}}) && (cnt_inc_s == target_r);
  end

  // Control FSM, configuration, history and registered outputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r     <= IDLE;
      pattern_r   <= DEF_PATTERN;
      len_r       <= 4'd3;
      overlap_r   <= 1'b1;
      target_r    <= {CW{1'b0}};
      hist_r      <= {PMAX{1'b0}};
      fill_r      <= 4'd0;
      match_cnt_r <= {CW{1'b0}};
      out_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      out_r <= match_s;
      err_r <= cfg_we && !((state_r == IDLE) && cfg_legal_s);
      if ((state_r == IDLE) && cfg_we && cfg_legal_s) begin
        pattern_r <= cfg_pattern;
        len_r     <= cfg_len;
        overlap_r <= cfg_overlap;
        target_r  <= cfg_target;
      end
      if (match_s) begin
        match_cnt_r <= cnt_inc_s;
      end
      case (state_r)
        IDLE, DONE: begin
          // stop outranks start; stop itself has no effect here
          if (start && !stop) begin
            match_cnt_r <= {CW{1'b0}};
            hist_r      <= {PMAX{1'b0}};
            fill_r      <= 4'd0;
            state_r     <= ARMED;
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
          end
        end
        ARMED, RUN: begin
          if (accept_s) begin
            hist_r <= hist_nxt_s;
            fill_r <= (match_s && !overlap_r) ? 4'd0 : fill_inc_s;
          end
          if (stop) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else if (hit_target_s) begin
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else if (match_s && !overlap_r) begin
            state_r <= ARMED;
          end else if (accept_s && (fill_inc_s >= len_r)) begin
            state_r <= RUN;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign out       = out_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign match_cnt = match_cnt_r;
  assign err       = err_r;

endmodule

// File: tb/tb_pattern_det_ctrl.sv
// Table-driven bench for pattern_det_ctrl with hand-computed expectations,
// plus a hand-written asynchronous clear sequence.
module tb_pattern_det_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic [7:0] cfg_target;
  logic       start, stop, in, in_valid;
  logic       out, busy, done, err;
  logic [7:0] match_cnt;

  int n_vec = 0;
  int n_err = 0;

  pattern_det_ctrl #(.PMAX(8), .CW(8)) dut (
    .clk(clk), .clr(clr), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
    .start(start), .stop(stop), .in(in), .in_valid(in_valid),
    .out(out), .busy(busy), .done(done), .match_cnt(match_cnt), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic       we;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ov;
    logic [7:0] tgt;
    logic       st, sp, iv, din;
    logic       eo, eb, ed;
    logic [7:0] ec;
    logic       ee;
  } vec_t;

  vec_t tbl[$];

  // data/control vector (no config write)
  function automatic void vd(string nm, logic st, logic sp, logic iv, logic din,
                             logic eo, logic eb, logic ed, logic [7:0] ec);
    vec_t v;
    v = '{nm, 1'b0, 8'h00, 4'd0, 1'b0, 8'h00, st, sp, iv, din, eo, eb, ed, ec, 1'b0};
    tbl.push_back(v);
  endfunction

  // config-write vector
  function automatic void vc(string nm, logic [7:0] pat, logic [3:0] len, logic ov,
                             logic [7:0] tgt, logic eb, logic ed, logic [7:0] ec, logic ee);
    vec_t v;
    v = '{nm, 1'b1, pat, len, ov, tgt, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, eb, ed, ec, ee};
    tbl.push_back(v);
  endfunction

  task automatic chk(string nm, logic eo, logic eb, logic ed, logic [7:0] ec, logic ee);
    n_vec++;
    if (out !== eo || busy !== eb || done !== ed || match_cnt !== ec || err !== ee) begin
      n_err++;
      $display("FAIL %s: got out=%0b busy=%0b done=%0b cnt=%0d err=%0b, want out=%0b busy=%0b done=%0b cnt=%0d err=%0b",
               nm, out, busy, done, match_cnt, err, eo, eb, ed, ec, ee);
    end
  endtask

  task automatic idle_inputs();
    cfg_we = 1'b0; cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0;
    cfg_target = 8'h00; start = 1'b0; stop = 1'b0; in = 1'b0; in_valid = 1'b0;
  endtask

  task automatic run_table();
    foreach (tbl[i]) begin
      cfg_we = tbl[i].we; cfg_pattern = tbl[i].pat; cfg_len = tbl[i].len;
      cfg_overlap = tbl[i].ov; cfg_target = tbl[i].tgt;
      start = tbl[i].st; stop = tbl[i].sp; in = tbl[i].din; in_valid = tbl[i].iv;
      @(posedge clk);
      #1;
      chk(tbl[i].nm, tbl[i].eo, tbl[i].eb, tbl[i].ed, tbl[i].ec, tbl[i].ee);
    end
    tbl.delete();
    idle_inputs();
  endtask

  // defaults 101/len3/overlap, stream 1,0,1,0,1 with a gap
  function automatic void seq_default(string p);
    vd({p, "_start"}, 1, 0, 0, 0, 0, 1, 0, 8'd0);
    vd({p, "_b1"},    0, 0, 1, 1, 0, 1, 0, 8'd0);
    vd({p, "_b2"},    0, 0, 1, 0, 0, 1, 0, 8'd0);
    vd({p, "_b3"},    0, 0, 1, 1, 1, 1, 0, 8'd1);
    vd({p, "_b4"},    0, 0, 1, 0, 0, 1, 0, 8'd1);
    vd({p, "_gap"},   0, 0, 0, 1, 0, 1, 0, 8'd1);
    vd({p, "_b5"},    0, 0, 1, 1, 1, 1, 0, 8'd2);
    vd({p, "_stop"},  0, 1, 0, 0, 0, 0, 0, 8'd2);
  endfunction

  initial begin
    idle_inputs();
    clr = 1'b1;
    #12;
    chk("reset_state", 0, 0, 0, 8'd0, 0);
    @(posedge clk);
    #1;
    clr = 1'b0;

    seq_default("a");
    vd("a_stop_idle", 0, 1, 0, 0, 0, 0, 0, 8'd2);
    vd("a_startstop", 1, 1, 0, 0, 0, 0, 0, 8'd2);

    // illegal lengths and write while busy leave defaults intact
    vc("d_len0", 8'hff, 4'd0, 0, 8'd1, 0, 0, 8'd2, 1);
    vc("d_len9", 8'hff, 4'd9, 0, 8'd1, 0, 0, 8'd2, 1);
    vd("d_start", 1, 0, 0, 0, 0, 1, 0, 8'd0);
    vc("d_cfg_busy", 8'b0110, 4'd4, 0, 8'd1, 1, 0, 8'd0, 1);
    vd("d_b1", 0, 0, 1, 1, 0, 1, 0, 8'd0);
    vd("d_b2", 0, 0, 1, 0, 0, 1, 0, 8'd0);
    vd("d_b3", 0, 0, 1, 1, 1, 1, 0, 8'd1);
    vd("d_b4", 0, 0, 1, 0, 0, 1, 0, 8'd1);
    vd("d_b5", 0, 0, 1, 1, 1, 1, 0, 8'd2);
    vd("d_stop", 0, 1, 0, 0, 0, 0, 0, 8'd2);

    // non-overlapping 101 over 1,0,1,0,1,1,0,1
    vc("b_cfg", 8'b101, 4'd3, 0, 8'd0, 0, 0, 8'd2, 0);
    vd("b_start", 1, 0, 0, 0, 0, 1, 0, 8'd0);
    vd("b_b1", 0, 0, 1, 1, 0, 1, 0, 8'd0);
    vd("b_b2", 0, 0, 1, 0, 0, 1, 0, 8'd0);
    vd("b_b3", 0, 0, 1, 1, 1, 1, 0, 8'd1);
    vd("b_b4", 0, 0, 1, 0, 0, 1, 0, 8'd1);
    vd("b_b5", 0, 0, 1, 1, 0, 1, 0, 8'd1);
    vd("b_b6", 0, 0, 1, 1, 0, 1, 0, 8'd1);
    vd("b_b7", 0, 0, 1, 0, 0, 1, 0, 8'd1);
    vd("b_start_run", 1, 0, 0, 0, 0, 1, 0, 8'd1);
    vc("b_cfg_busy", 8'h00, 4'd2, 1, 8'd0, 1, 0, 8'd1, 1);
    vd("b_b8", 0, 0, 1, 1, 1, 1, 0, 8'd2);
    vd("b_stop", 0, 1, 0, 0, 0, 0, 0, 8'd2);

    // 1101, target 2, stream 1101101 with gaps
    vc("c_cfg", 8'b1101, 4'd4, 1, 8'd2, 0, 0, 8'd2, 0);
    vd("c_start", 1, 0, 0, 0, 0, 1, 0, 8'd0);
    vd("c_b1",   0, 0, 1, 1, 0, 1, 0, 8'd0);
    vd("c_gap1", 0, 0, 0, 0, 0, 1, 0, 8'd0);
    vd("c_b2",   0, 0, 1, 1, 0, 1, 0, 8'd0);
    vd("c_b3",   0, 0, 1, 0, 0, 1, 0, 8'd0);
    vd("c_gap2", 0, 0, 0, 1, 0, 1, 0, 8'd0);
    vd("c_b4",   0, 0, 1, 1, 1, 1, 0, 8'd1);
    vd("c_b5",   0, 0, 1, 1, 0, 1, 0, 8'd1);
    vd("c_b6",   0, 0, 1, 0, 0, 1, 0, 8'd1);
    vd("c_gap3", 0, 0, 0, 1, 0, 1, 0, 8'd1);
    vd("c_b7",   0, 0, 1, 1, 1, 0, 1, 8'd2);
    vd("c_after1", 0, 0, 1, 1, 0, 0, 1, 8'd2);
    vd("c_after2", 0, 0, 1, 0, 0, 0, 1, 8'd2);
    vd("c_stop_done", 0, 1, 0, 0, 0, 0, 1, 8'd2);
    vc("c_cfg_done", 8'h00, 4'd5, 0, 8'd0, 0, 1, 8'd2, 1);
    vd("c_restart", 1, 0, 0, 0, 0, 1, 0, 8'd0);
    vd("c_r1", 0, 0, 1, 1, 0, 1, 0, 8'd0);
    vd("c_r2", 0, 0, 1, 1, 0, 1, 0, 8'd0);
    vd("c_r3", 0, 0, 1, 0, 0, 1, 0, 8'd0);
    vd("c_stop_match", 0, 1, 1, 1, 1, 0, 0, 8'd1);

    // run up to one bit before a match for the async clear test
    vd("e_start", 1, 0, 0, 0, 0, 1, 0, 8'd0);
    vd("e_b1", 0, 0, 1, 1, 0, 1, 0, 8'd0);
    vd("e_b2", 0, 0, 1, 1, 0, 1, 0, 8'd0);
    vd("e_b3", 0, 0, 1, 0, 0, 1, 0, 8'd0);
    vd("e_b4", 0, 0, 1, 1, 1, 1, 0, 8'd1);
    vd("e_b5", 0, 0, 1, 1, 0, 1, 0, 8'd1);
    vd("e_b6", 0, 0, 1, 0, 0, 1, 0, 8'd1);
    run_table();

    // next accepted 1 would match; clear lands between edges
    in = 1'b1;
    in_valid = 1'b1;
    #2;
    clr = 1'b1;
    #1;
    chk("clr_async", 0, 0, 0, 8'd0, 0);
    @(posedge clk);
    #1;
    chk("clr_hold_edge", 0, 0, 0, 8'd0, 0);
    #2;
    clr = 1'b0;
    idle_inputs();

    vd("p_idle", 0, 0, 1, 1, 0, 0, 0, 8'd0);
    seq_default("p");
    run_table();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
